// File: rtl/cic_integrator_decimator.sv
// cic_integrator_decimator
//   Integrator section and rate-R decimator of the CIC decimation filter.
//   It runs N cascaded wrap-around integrators at the input sample rate.
//   Every R-th accepted sample, the post-update last integrator value is
//   registered on y, and y_valid pulses for one clock.
//
// Ports
//   clk      in   1           system clock; all logic uses the rising edge
//   rst      in   1           synchronous reset, active-high
//   x_valid  in   1           input sample strobe
//   x        in   IN_WIDTH    signed input sample
//   y        out  ACC_WIDTH   signed decimated output (to the comb chain)
//   y_valid  out  1           one-cycle strobe; y holds a new sample
//   phase    out  PHASE_WIDTH number of accepted samples in the current group
module cic_integrator_decimator #(
  parameter int N         = 3,
  parameter int R         = 8,
  parameter int IN_WIDTH  = 12,
  parameter int ACC_WIDTH = 21,
  localparam int PHASE_WIDTH = (R > 1) ? $clog2(R) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        x_valid,
  input  logic signed [IN_WIDTH-1:0]  x,
  output logic signed [ACC_WIDTH-1:0] y,
  output logic                        y_valid,
  output logic [PHASE_WIDTH-1:0]      phase
);

  logic signed [ACC_WIDTH-1:0] acc [N];
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] acc_last_next;
  logic                        last_phase;

  assign x_ext      = ACC_WIDTH'(x);
  assign last_phase = (phase == PHASE_WIDTH'(R - 1));

  // y carries the value the last integrator holds after this edge, so the
  // output is aligned with the sample that completes the group.
  generate
    if (N == 1) begin : g_single
      assign acc_last_next = acc[0] + x_ext;
    end else begin : g_multi
      assign acc_last_next = acc[N-1] + acc[N-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        acc[k] <= '0;
      end
      phase   <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (x_valid) begin
        acc[0] <= acc[0] + x_ext;
        // Each stage adds the previous stage's pre-edge value (one register per stage).
        for (int k = 1; k < N; k++) begin
          acc[k] <= acc[k] + acc[k-1];
        end
        if (last_phase) begin
          phase   <= '0;
          y       <= acc_last_next;
          y_valid <= 1'b1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule
